mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared refill arbiter for the I- and D-caches: grants one miss at a time,
// streams a 16-byte block out of main memory and steers the returns to the winner.
module mem_arbiter #(
  parameter int MEM_LAT   = 4,
  parameter int BLK_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_in,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        busy
);

  localparam int KW = $clog2(BLK_WORDS);
  localparam int CW = $clog2(BLK_WORDS + 1);
  localparam int QW = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    QUIET, IDLE, ISSUE, DRAIN, DONE
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [KW-1:0] k;
  logic [CW-1:0] outst;
  logic [CW-1:0] rcv;
  logic [15:0]   base;
  logic          gnt_d;
  logic          last_grant;
  logic          accept;
  logic          pick_d;
  logic          fill;
  logic          done;

  // only reads this block issued may be accepted; stale returns fall through
  assign accept = mem_data_valid && (outst != '0);
  assign pick_d = d_miss && (!i_miss || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= QUIET;
      qcnt       <= '0;
      k          <= '0;
      outst      <= '0;
      rcv        <= '0;
      base       <= '0;
      gnt_d      <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      outst <= outst + CW'(mem_en) - CW'(accept);
      if (accept)
        rcv <= rcv + CW'(1);
      unique case (state)
        QUIET: begin
          if (qcnt == QW'(MEM_LAT - 1))
            state <= IDLE;
          else
            qcnt <= qcnt + QW'(1);
        end
        IDLE: begin
          if (i_miss || d_miss) begin
            gnt_d      <= pick_d;
            last_grant <= pick_d;
            base       <= (pick_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
            k          <= '0;
            rcv        <= '0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          k <= k + KW'(1);
          if (k == KW'(BLK_WORDS - 1))
            state <= DRAIN;
        end
        DRAIN: begin
          if (rcv == CW'(BLK_WORDS) ||
              (accept && rcv == CW'(BLK_WORDS - 1)))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= QUIET;
      endcase
    end
  end

  assign mem_en      = !rst && (state == ISSUE);
  assign mem_addr    = mem_en ? base + 16'({k, 1'b0}) : '0;
  assign fill        = !rst && accept;
  assign i_fill_we   = fill && !gnt_d;
  assign d_fill_we   = fill && gnt_d;
  assign fill_addr   = fill ? base + 16'({rcv, 1'b0}) : '0;
  assign fill_data   = rst ? '0 : mem_data_in;
  assign done        = !rst && (state == DONE);
  assign i_fill_done = done && !gnt_d;
  assign d_fill_done = done && gnt_d;
  assign busy        = !rst && (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model
// returning addr ^ 16'hA5A5 for every issued read.
module tb_mem_arbiter;

  localparam int MEM_LAT   = 4;
  localparam int BLK_WORDS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        i_fill_we;
  logic        d_fill_we;
  logic [15:0] fill_addr;
  logic [15:0] fill_data;
  logic        i_fill_done;
  logic        d_fill_done;
  logic        busy;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic        mv  = 1'b0;
  logic        inj = 1'b0;
  logic [15:0] md  = '0;
  int          rq_t[$];
  logic [15:0] rq_a[$];

  assign mem_data_valid = mv | inj;
  assign mem_data_in    = mv ? md : (inj ? 16'hDEAD : 16'h0000);

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BLK_WORDS(BLK_WORDS)) dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // memory: a read seen in cycle c returns during cycle c+MEM_LAT
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rq_t.size() > 0 && rq_t[0] == cyc) begin
      mv = 1'b1;
      md = rq_a[0] ^ 16'hA5A5;
      void'(rq_t.pop_front());
      void'(rq_a.pop_front());
    end else begin
      mv = 1'b0;
      md = '0;
    end
  end

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      rq_t.push_back(cyc + MEM_LAT);
      rq_a.push_back(mem_addr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serves one block granted in the current cycle T (state IDLE).
  task automatic serve(input bit is_d, input logic [15:0] base,
                       input bit early, input bit raise_other,
                       input logic [15:0] oaddr);
    logic [5:0]  gv;
    logic [5:0]  ev;
    logic [15:0] ea;
    logic        en;
    logic        fl;
    logic        dn;
    @(negedge clk);
    gv = {mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};
    nchk++;
    if (gv !== 6'b000000) begin
      nerr++;
      $display("FAIL grant_idle: got %b want 000000", gv);
    end
    for (int r = 1; r <= 13; r++) begin
      tick();
      if (r == 3 && raise_other) begin
        if (is_d) begin i_miss = 1'b1; i_miss_addr = oaddr; end
        else begin d_miss = 1'b1; d_miss_addr = oaddr; end
      end
      if (r == 4) begin
        if (is_d) d_miss_addr = 16'h0F0F;
        else i_miss_addr = 16'h0F0F;
      end
      if (r == 6 && early) begin
        if (is_d) d_miss = 1'b0;
        else i_miss = 1'b0;
      end
      @(negedge clk);
      en = (r <= BLK_WORDS);
      fl = (r >= 5 && r <= 12);
      dn = (r == 13);
      ev = {en, fl & ~is_d, fl & is_d, dn & ~is_d, dn & is_d, 1'b1};
      gv = {mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};
      nchk++;
      if (gv !== ev) begin
        nerr++;
        $display("FAIL ctl base=%h r=%0d: got %b want %b", base, r, gv, ev);
      end
      if (en) begin
        ea = base + 16'(2 * (r - 1));
        nchk++;
        if (mem_addr !== ea) begin
          nerr++;
          $display("FAIL mem_addr r=%0d: got %h want %h", r, mem_addr, ea);
        end
      end
      if (fl) begin
        ea = base + 16'(2 * (r - 5));
        nchk++;
        if ({fill_addr, fill_data} !== {ea, ea ^ 16'hA5A5}) begin
          nerr++;
          $display("FAIL fill r=%0d: got %h/%h want %h/%h",
                   r, fill_addr, fill_data, ea, ea ^ 16'hA5A5);
        end
      end
    end
    tick();
    if (is_d) d_miss = 1'b0;
    else i_miss = 1'b0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    i_miss = 1'b0;
    d_miss = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int q = 0; q < MEM_LAT; q++) tick();
  endtask

  task automatic test_reset;
    logic [5:0] gv;
    rst = 1'b1;
    d_miss = 1'b1;
    d_miss_addr = 16'h1236;
    inj = 1'b1;
    tick();
    tick();
    @(negedge clk);
    nchk++;
    if ({mem_en, mem_addr, i_fill_we, d_fill_we, fill_addr, fill_data,
         i_fill_done, d_fill_done, busy} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got en=%b a=%h we=%b%b fa=%h fd=%h dn=%b%b busy=%b, want all 0",
               mem_en, mem_addr, i_fill_we, d_fill_we, fill_addr, fill_data,
               i_fill_done, d_fill_done, busy);
    end
    tick();
    rst = 1'b0;
    for (int q = 1; q <= MEM_LAT; q++) begin
      @(negedge clk);
      gv = {mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};
      nchk++;
      if (gv !== 6'b000001) begin
        nerr++;
        $display("FAIL quiet q=%0d: got %b want 000001", q, gv);
      end
      tick();
    end
    inj = 1'b0;
  endtask

  task automatic test_single_d;
    serve(1'b1, 16'h1230, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    nchk++;
    if ({busy, mem_en, i_fill_we, d_fill_we} !== 4'b0000) begin
      nerr++;
      $display("FAIL single_d_idle: got %b want 0000",
               {busy, mem_en, i_fill_we, d_fill_we});
    end
    tick();
  endtask

  task automatic test_simultaneous;
    reset_dut();
    i_miss = 1'b1; i_miss_addr = 16'h2004;
    d_miss = 1'b1; d_miss_addr = 16'h3018;
    serve(1'b1, 16'h3010, 1'b0, 1'b0, 16'h0);
    serve(1'b0, 16'h2000, 1'b0, 1'b1, 16'h7776);
    serve(1'b1, 16'h7770, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_back_to_back;
    d_miss = 1'b1; d_miss_addr = 16'h8882;
    i_miss = 1'b1; i_miss_addr = 16'h9990;
    serve(1'b0, 16'h9990, 1'b0, 1'b0, 16'h0);
    serve(1'b1, 16'h8880, 1'b1, 1'b0, 16'h0);
    i_miss = 1'b1; i_miss_addr = 16'hA00E;
    d_miss = 1'b1; d_miss_addr = 16'hB00C;
    serve(1'b0, 16'hA000, 1'b0, 1'b0, 16'h0);
    serve(1'b1, 16'hB000, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset_mid_fill;
    logic [5:0]  gv;
    logic [15:0] ea;
    d_miss = 1'b1;
    d_miss_addr = 16'h444A;
    for (int r = 1; r <= 7; r++) begin
      tick();
      @(negedge clk);
      if (r >= 5) begin
        ea = 16'h4440 + 16'(2 * (r - 5));
        nchk++;
        if ({d_fill_we, fill_addr} !== {1'b1, ea}) begin
          nerr++;
          $display("FAIL pre_abort r=%0d: got %b/%h want 1/%h",
                   r, d_fill_we, fill_addr, ea);
        end
      end
    end
    tick();
    rst = 1'b1;
    d_miss = 1'b0;
    @(negedge clk);
    gv = {mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};
    nchk++;
    if (gv !== 6'b000000) begin
      nerr++;
      $display("FAIL abort_outputs: got %b want 000000", gv);
    end
    tick();
    rst = 1'b0;
    for (int q = 1; q <= MEM_LAT; q++) begin
      @(negedge clk);
      gv = {mem_en, i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy};
      nchk++;
      if (gv !== 6'b000001) begin
        nerr++;
        $display("FAIL stale q=%0d: got %b want 000001", q, gv);
      end
      tick();
    end
    d_miss = 1'b1;
    d_miss_addr = 16'h4446;
    serve(1'b1, 16'h4440, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_edge;
    inj = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      nchk++;
      if ({busy, mem_en, i_fill_we, d_fill_we} !== 4'b0000) begin
        nerr++;
        $display("FAIL spurious_idle s=%0d: got %b want 0000",
                 s, {busy, mem_en, i_fill_we, d_fill_we});
      end
      tick();
    end
    inj = 1'b0;
    i_miss = 1'b1;
    i_miss_addr = 16'hFFFE;
    serve(1'b0, 16'hFFF0, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    nchk++;
    if ({busy, mem_en, i_fill_done, d_fill_done} !== 4'b0000) begin
      nerr++;
      $display("FAIL edge_idle: got %b want 0000",
               {busy, mem_en, i_fill_done, d_fill_done});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_d();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_fill();
    test_edge();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
